// File: rtl/noc_pkg.sv
// noc_pkg: shared AXI-Stream beat type, width defaults and arbiter
// state encoding for the mesh ingress blocks.
package noc_pkg;

    localparam int DEF_TDATAW = 32;
    localparam int DEF_TDESTW = 4;
    localparam int DEF_TIDW   = 3;

    typedef struct packed {
        logic [DEF_TDATAW-1:0] data;
        logic                  last;
        logic [DEF_TDESTW-1:0] dest;
        logic [DEF_TIDW-1:0]   id;
    } axis_beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry AXI-Stream register slice, fully registered
// in both directions; the beat type is a parameter so mesh ports can share it.
module axis_skid_buffer
    import noc_pkg::*;
#(
    parameter type beat_t = axis_beat_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    input  beat_t in_beat_i,
    output logic  out_valid_o,
    input  logic  out_ready_i,
    output beat_t out_beat_o
);

    logic  v0_q, v0_d;
    logic  v1_q, v1_d;
    logic  rdy_q;
    beat_t e0_q, e0_d;
    beat_t e1_q, e1_d;
    logic  push, pop;

    assign push = in_valid_i && rdy_q;
    assign pop  = v0_q && out_ready_i;

    // Entry 0 is the head; entry 1 only fills when the head is stalled.
    always_comb begin
        v0_d = v0_q;
        v1_d = v1_q;
        e0_d = e0_q;
        e1_d = e1_q;
        if (pop) begin
            if (v1_q) begin
                e0_d = e1_q;
                v1_d = 1'b0;
            end else if (push) begin
                e0_d = in_beat_i;
            end else begin
                v0_d = 1'b0;
            end
        end else if (push) begin
            if (v0_q) begin
                e1_d = in_beat_i;
                v1_d = 1'b1;
            end else begin
                e0_d = in_beat_i;
                v0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            rdy_q <= 1'b1;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            v0_q  <= v0_d;
            v1_q  <= v1_d;
            rdy_q <= !v1_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = v0_q;
    assign out_beat_o  = e0_q;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-level round-robin arbiter sharing one mesh
// ingress port among NUM_SRC AXI-Stream requesters.
module axis_pkt_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int TDATAW  = DEF_TDATAW,
    parameter int TDESTW  = DEF_TDESTW,
    parameter int TIDW    = DEF_TIDW
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0]             s_tvalid,
    output logic [NUM_SRC-1:0]             s_tready,
    input  logic [NUM_SRC-1:0][TDATAW-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]             s_tlast,
    input  logic [NUM_SRC-1:0][TDESTW-1:0] s_tdest,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [TDATAW-1:0]              m_tdata,
    output logic                           m_tlast,
    output logic [TDESTW-1:0]              m_tdest,
    output logic [TIDW-1:0]                m_tid,
    output logic                           busy
);

    localparam int PTRW = $clog2(NUM_SRC);

    typedef logic [PTRW-1:0] ptr_t;

    typedef struct packed {
        logic [TDATAW-1:0] data;
        logic              last;
        logic [TDESTW-1:0] dest;
        logic [TIDW-1:0]   id;
    } beat_t;

    if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
        $error("axis_pkt_arbiter: NUM_SRC must be in 2..8");
    end
    if (TIDW < PTRW) begin : g_bad_tidw
        $error("axis_pkt_arbiter: TIDW too narrow for NUM_SRC");
    end

    function automatic ptr_t rr_idx(input ptr_t base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= NUM_SRC) j = j - NUM_SRC;
        return ptr_t'(j);
    endfunction

    function automatic ptr_t next_ptr(input ptr_t g);
        return (int'(g) == NUM_SRC - 1) ? '0 : g + 1'b1;
    endfunction

    arb_state_e state_q, state_d;
    ptr_t       rr_ptr_q, rr_ptr_d;
    ptr_t       grant_q, grant_d;
    ptr_t       win_idx;
    logic       win_valid;
    logic       skid_rdy;
    logic       push;
    beat_t      push_beat;
    logic       out_valid;
    beat_t      out_beat;

    // Scan from the highest offset down so the nearest requester wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (s_tvalid[rr_idx(rr_ptr_q, k)]) begin
                win_valid = 1'b1;
                win_idx   = rr_idx(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        s_tready = '0;
        if (state_q == LOCK) s_tready[grant_q] = skid_rdy;
    end

    assign push = (state_q == LOCK) && s_tvalid[grant_q] && skid_rdy;

    always_comb begin
        push_beat      = '0;
        push_beat.data = s_tdata[grant_q];
        push_beat.last = s_tlast[grant_q];
        push_beat.dest = s_tdest[grant_q];
        push_beat.id   = TIDW'(grant_q);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (push && s_tlast[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr(grant_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    axis_skid_buffer #(
        .beat_t (beat_t)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (push),
        .in_ready_o  (skid_rdy),
        .in_beat_i   (push_beat),
        .out_valid_o (out_valid),
        .out_ready_i (m_tready),
        .out_beat_o  (out_beat)
    );

    assign m_tvalid = out_valid;
    assign m_tdata  = out_beat.data;
    assign m_tlast  = out_beat.last;
    assign m_tdest  = out_beat.dest;
    assign m_tid    = out_beat.id;
    assign busy     = (state_q == LOCK);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed scenarios plus random traffic, checked
// every cycle against a packet-level round-robin model with a beat queue.
module tb_axis_pkt_arbiter;
    import noc_pkg::*;

    localparam int N   = 3;
    localparam int DW  = 32;
    localparam int DSW = 4;
    localparam int IW  = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [N-1:0]           s_tvalid, s_tready, s_tlast;
    logic [N-1:0][DW-1:0]   s_tdata;
    logic [N-1:0][DSW-1:0]  s_tdest;
    logic                   m_tvalid, m_tready, m_tlast, busy;
    logic [DW-1:0]          m_tdata;
    logic [DSW-1:0]         m_tdest;
    logic [IW-1:0]          m_tid;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(
        .NUM_SRC (N),
        .TDATAW  (DW),
        .TDESTW  (DSW),
        .TIDW    (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tdest  (s_tdest),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tdest  (m_tdest),
        .m_tid    (m_tid),
        .busy     (busy)
    );

    typedef struct {
        logic [DW-1:0]  data;
        logic           last;
        logic [DSW-1:0] dest;
        int             gap;
    } sbeat_t;

    typedef struct {
        logic [DW-1:0]  data;
        logic           last;
        logic [DSW-1:0] dest;
        int             tid;
    } obeat_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic          last;
        int            tid;
    } log_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    sbeat_t       sq[N][$];
    int           gap_cnt[N];
    bit           gap_init[N];
    logic [N-1:0] acc = '0;
    obeat_t       mq[$];
    bit           m_locked = 0;
    int           m_grant = 0;
    int           m_rr = 0;
    log_t         lg[$];
    bit           busy_h[int];
    logic [N-1:0] rdy_h[int];
    int           mr_mode = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: one grant per packet in round-robin order, outputs
    // delayed through a queue holding at most two beats.
    always @(negedge clk) begin
        logic [N-1:0] er;
        bit push, pop;
        busy_h[cyc] = busy;
        rdy_h[cyc]  = s_tready;
        if (!rst_n) begin
            chk("rst_m_tvalid", 64'(m_tvalid), 0);
            chk("rst_s_tready", 64'(s_tready), 0);
            chk("rst_busy", 64'(busy), 0);
            mq.delete();
            m_locked = 0;
            m_grant  = 0;
            m_rr     = 0;
            acc      = '0;
        end else begin
            er = '0;
            if (m_locked && mq.size() < 2) er[m_grant] = 1'b1;
            chk("s_tready", 64'(s_tready), 64'(er));
            chk("busy", 64'(busy), 64'(m_locked));
            chk("m_tvalid", 64'(m_tvalid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_tdata", 64'(m_tdata), 64'(mq[0].data));
                chk("m_tlast", 64'(m_tlast), 64'(mq[0].last));
                chk("m_tdest", 64'(m_tdest), 64'(mq[0].dest));
                chk("m_tid", 64'(m_tid), 64'(mq[0].tid));
            end
            if (m_tvalid && m_tready)
                lg.push_back('{cyc, m_tdata, m_tlast, int'(m_tid)});
            acc  = s_tvalid & s_tready;
            push = m_locked && s_tvalid[m_grant] && mq.size() < 2;
            pop  = mq.size() > 0 && m_tready;
            if (pop) void'(mq.pop_front());
            if (push)
                mq.push_back('{s_tdata[m_grant], s_tlast[m_grant],
                               s_tdest[m_grant], m_grant});
            if (!m_locked) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_locked && s_tvalid[(m_rr + k) % N]) begin
                        m_grant  = (m_rr + k) % N;
                        m_locked = 1;
                    end
                end
            end else if (push && s_tlast[m_grant]) begin
                m_locked = 0;
                m_rr     = (m_grant + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (mr_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'b0;
            default: m_tready = ($urandom_range(0, 3) != 0);
        endcase
        for (int i = 0; i < N; i++) begin
            if (acc[i] && sq[i].size() > 0) begin
                void'(sq[i].pop_front());
                gap_init[i] = 0;
            end
            s_tvalid[i] = 1'b0;
            if (sq[i].size() > 0) begin
                if (!gap_init[i]) begin
                    gap_cnt[i]  = sq[i][0].gap;
                    gap_init[i] = 1;
                end
                if (gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                end else begin
                    s_tvalid[i] = 1'b1;
                    s_tdata[i]  = sq[i][0].data;
                    s_tlast[i]  = sq[i][0].last;
                    s_tdest[i]  = sq[i][0].dest;
                end
            end
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            sq[i].delete();
            gap_init[i] = 0;
        end
        s_tvalid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        step();
        step();
        rst_n = 1'b1;
        lg.delete();
    endtask

    task automatic add_pkt(input int s, input int n, input logic [31:0] base,
                           input logic [3:0] dest, input int gi = -1,
                           input int g = 0);
        for (int b = 0; b < n; b++)
            sq[s].push_back('{base + b, b == n - 1, dest,
                              (b == gi) ? g : 0});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        bit pend;
        c = 0;
        pend = 1;
        while (pend && c < budget) begin
            pend = m_locked || mq.size() > 0;
            for (int i = 0; i < N; i++) if (sq[i].size() > 0) pend = 1;
            if (pend) begin
                step();
                c++;
            end
        end
        if (pend) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles", name, c);
        end
        step();
        step();
    endtask

    task automatic chk_tids(input string name, input int exp[$]);
        int got[$];
        for (int k = 0; k < lg.size(); k++)
            if (k == 0 || lg[k-1].last) got.push_back(lg[k].tid);
        chk({name, "_npkts"}, 64'(got.size()), 64'(exp.size()));
        for (int k = 0; k < got.size() && k < exp.size(); k++)
            chk({name, "_tid"}, 64'(got[k]), 64'(exp[k]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int total_in;
        int pk;
        logic [31:0] ed;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        s_tdest  = '0;
        m_tready = 1'b1;
        #2 rst_n = 1'b0;
        #5;
        chk("reset_m_tvalid", 64'(m_tvalid), 0);
        chk("reset_m_tdata", 64'(m_tdata), 0);
        chk("reset_m_tlast", 64'(m_tlast), 0);
        chk("reset_m_tdest", 64'(m_tdest), 0);
        chk("reset_m_tid", 64'(m_tid), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_s_tready", 64'(s_tready), 0);
        step();
        rst_n = 1'b1;
        lg.delete();
        step();

        // Single 4-beat packet on source 0
        add_pkt(0, 4, 32'h11, 4'h1);
        step();
        t0 = cyc;
        wait_idle("t1", 40);
        chk("t1_beats", 64'(lg.size()), 4);
        for (int k = 0; k < lg.size() && k < 4; k++) begin
            chk("t1_data", 64'(lg[k].data), 64'(32'h11 + k));
            chk("t1_cycle", 64'(lg[k].cyc), 64'(t0 + 2 + k));
            chk("t1_last", 64'(lg[k].last), 64'(k == 3));
            chk("t1_tid", 64'(lg[k].tid), 0);
        end
        chk("t1_busy_first", 64'(busy_h[t0 + 1]), 1);
        chk("t1_busy_tlast", 64'(busy_h[t0 + 4]), 1);
        chk("t1_busy_after", 64'(busy_h[t0 + 5]), 0);

        // Contention: two 3-beat packets each on sources 0 and 1
        do_reset();
        for (int p = 0; p < 2; p++) begin
            add_pkt(0, 3, 32'h100 + p * 16, 4'h2);
            add_pkt(1, 3, 32'h200 + p * 16, 4'h3);
        end
        step();
        wait_idle("t2", 80);
        chk_tids("t2", '{0, 1, 0, 1});
        chk("t2_beats", 64'(lg.size()), 12);
        for (int k = 0; k < lg.size() && k < 12; k++) begin
            ed = ((k % 6) < 3 ? 32'h100 : 32'h200) + (k / 6) * 16 + (k % 3);
            chk("t2_data", 64'(lg[k].data), 64'(ed));
            if (k > 0)
                chk("t2_spacing", 64'(lg[k].cyc - lg[k-1].cyc),
                    64'((k % 3 == 0) ? 2 : 1));
        end

        // Backpressure: 5 stalled cycles inside a 6-beat packet
        do_reset();
        add_pkt(0, 6, 32'h21, 4'h5);
        step();
        t0 = cyc;
        step();
        step();
        mr_mode = 1;
        repeat (5) step();
        mr_mode = 0;
        wait_idle("t3", 60);
        chk("t3_beats", 64'(lg.size()), 6);
        for (int k = 0; k < lg.size() && k < 6; k++) begin
            chk("t3_data", 64'(lg[k].data), 64'(32'h21 + k));
            chk("t3_last", 64'(lg[k].last), 64'(k == 5));
        end
        if (lg.size() > 1) chk("t3_release", 64'(lg[1].cyc), 64'(t0 + 8));
        chk("t3_rdy_before", 64'(rdy_h[t0 + 3]), 1);
        chk("t3_rdy_full", 64'(rdy_h[t0 + 4]), 0);
        chk("t3_rdy_stall", 64'(rdy_h[t0 + 6]), 0);
        chk("t3_rdy_back", 64'(rdy_h[t0 + 9]), 1);
        chk("t3_busy_stall", 64'(busy_h[t0 + 5]), 1);

        // Gap inside source 1's packet while source 0 waits
        do_reset();
        add_pkt(1, 4, 32'h41, 4'h6, 2, 3);
        step();
        add_pkt(0, 2, 32'h31, 4'h7);
        wait_idle("t4", 60);
        chk_tids("t4", '{1, 0});
        chk("t4_beats", 64'(lg.size()), 6);
        for (int k = 0; k < lg.size() && k < 6; k++)
            chk("t4_data", 64'(lg[k].data),
                64'(k < 4 ? 32'h41 + k : 32'h31 + k - 4));

        // Wrap with single-beat packets on all sources
        do_reset();
        add_pkt(0, 1, 32'h51, 4'h1);
        add_pkt(1, 1, 32'h52, 4'h1);
        add_pkt(2, 1, 32'h53, 4'h1);
        add_pkt(0, 1, 32'h54, 4'h1);
        step();
        wait_idle("t5", 40);
        chk_tids("t5", '{0, 1, 2, 0});
        for (int k = 0; k < lg.size() && k < 4; k++)
            chk("t5_data", 64'(lg[k].data), 64'(32'h51 + k));

        // Reset in the middle of a packet from source 2
        lg.delete();
        add_pkt(2, 4, 32'h61, 4'h2);
        step();
        step();
        step();
        #2;
        chk("pre_rst_busy", 64'(busy), 1);
        chk("pre_rst_m_tvalid", 64'(m_tvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_m_tvalid", 64'(m_tvalid), 0);
        chk("async_rst_s_tready", 64'(s_tready), 0);
        chk("async_rst_busy", 64'(busy), 0);
        clear_src();
        step();
        step();
        rst_n = 1'b1;
        lg.delete();
        add_pkt(0, 1, 32'h71, 4'h3);
        add_pkt(1, 1, 32'h72, 4'h3);
        add_pkt(2, 1, 32'h73, 4'h3);
        step();
        wait_idle("t6", 40);
        chk_tids("t6", '{0, 1, 2});

        // Random traffic with gaps and random backpressure
        do_reset();
        mr_mode  = 2;
        total_in = 0;
        pk       = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (sq[i].size() < 4 && $urandom_range(0, 7) == 0) begin
                    int n;
                    n = $urandom_range(1, 5);
                    add_pkt(i, n, {8'(i), 8'(pk), 16'h0},
                            4'($urandom_range(0, 15)),
                            $urandom_range(0, n - 1),
                            ($urandom_range(0, 2) == 0) ?
                                $urandom_range(1, 3) : 0);
                    total_in += n;
                    pk++;
                end
            end
            step();
        end
        mr_mode = 0;
        wait_idle("rand", 600);
        chk("rand_beat_count", 64'(lg.size()), 64'(total_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
